// File: rtl/fp_pkg.sv
// Shared types and width/bias helpers for the floating-point unpack stream.
package fp_pkg;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic subn;
    } fp_class_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Two extra bits cover bias+1 and the most negative normalised subnormal exponent.
    function automatic int unsigned out_exp_w(input int unsigned exp_w);
        return exp_w + 32'd2;
    endfunction

    function automatic int unsigned lzc_w(input int unsigned width);
        return $clog2(width + 32'd1);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zero bits above the most significant set bit.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH = 23
) (
    input  logic [WIDTH-1:0]          value,
    output logic [lzc_w(WIDTH)-1:0]   count
);

    localparam int unsigned CNT_W = lzc_w(WIDTH);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fp_unpack_stream.sv
// Two-stage IEEE-754 unpacker with valid/ready on both sides: S1 classifies, S2 normalises.
// Define FP_UNPACK_NORM_EN to normalise subnormals through a leading-zero count.
module fp_unpack_stream
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [EXP_W+MAN_W:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sign,
    output logic [out_exp_w(EXP_W)-1:0]  out_exp,
    output logic [MAN_W:0]               out_sig,
    output logic                         out_nan,
    output logic                         out_inf,
    output logic                         out_zero,
    output logic                         out_subn
);

    localparam int unsigned       OW       = out_exp_w(EXP_W);
    localparam logic [OW-1:0]     BIAS_V   = OW'(bias(EXP_W));
    localparam logic [OW-1:0]     ONE_V    = OW'(1);
    localparam logic [OW-1:0]     EXP_SPEC = BIAS_V + ONE_V;
    localparam logic [OW-1:0]     EXP_SUBN = ONE_V - BIAS_V;

    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    fp_class_t        in_cls;
    logic             accept;
    logic             load2;

    logic             v1_q, sign1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [MAN_W-1:0] man1_q;
    fp_class_t        cls1_q;

    logic             v2_q, sign2_q;
    logic [OW-1:0]    exp2_q;
    logic [MAN_W:0]   sig2_q;
    fp_class_t        cls2_q;

    logic [OW-1:0]    exp_d;
    logic [MAN_W:0]   sig_d;

    assign in_exp = in_data[EXP_W+MAN_W-1:MAN_W];
    assign in_man = in_data[MAN_W-1:0];

    always_comb begin
        in_cls      = '0;
        in_cls.nan  = (&in_exp) && (|in_man);
        in_cls.inf  = (&in_exp) && !(|in_man);
        in_cls.zero = !(|in_exp) && !(|in_man);
        in_cls.subn = !(|in_exp) && (|in_man);
    end

    assign load2    = !v2_q || out_ready;
    assign in_ready = rst_n && (!v1_q || load2);
    assign accept   = in_valid && in_ready;

`ifdef FP_UNPACK_NORM_EN
    logic [lzc_w(MAN_W)-1:0] lz_cnt;
    logic [MAN_W-1:0]        man_shift;

    fp_lzc #(
        .WIDTH (MAN_W)
    ) u_lzc (
        .value (man1_q),
        .count (lz_cnt)
    );

    // Shifting by z leaves the leading one at the top; the extra place is the appended zero.
    assign man_shift = man1_q << lz_cnt;
`endif

    always_comb begin
        exp_d = '0;
        sig_d = '0;
        if (cls1_q.zero) begin
            exp_d = '0;
            sig_d = '0;
        end else if (cls1_q.nan || cls1_q.inf) begin
            exp_d = EXP_SPEC;
            sig_d = {1'b0, man1_q};
        end else if (cls1_q.subn) begin
`ifdef FP_UNPACK_NORM_EN
            exp_d = EXP_SUBN - OW'(lz_cnt) - ONE_V;
            sig_d = {man_shift, 1'b0};
`else
            exp_d = EXP_SUBN;
            sig_d = {1'b0, man1_q};
`endif
        end else begin
            exp_d = OW'(exp1_q) - BIAS_V;
            sig_d = {1'b1, man1_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            man1_q  <= '0;
            cls1_q  <= '0;
        end else if (accept) begin
            v1_q    <= 1'b1;
            sign1_q <= in_data[EXP_W+MAN_W];
            exp1_q  <= in_exp;
            man1_q  <= in_man;
            cls1_q  <= in_cls;
        end else if (load2) begin
            v1_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            exp2_q  <= '0;
            sig2_q  <= '0;
            cls2_q  <= '0;
        end else if (load2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign2_q <= sign1_q;
                exp2_q  <= exp_d;
                sig2_q  <= sig_d;
                cls2_q  <= cls1_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_sign  = sign2_q;
    assign out_exp   = exp2_q;
    assign out_sig   = sig2_q;
    assign out_nan   = cls2_q.nan;
    assign out_inf   = cls2_q.inf;
    assign out_zero  = cls2_q.zero;
    assign out_subn  = cls2_q.subn;

endmodule

// File: tb/tb_fp_unpack_stream.sv
// Scoreboard bench for fp_unpack_stream (binary32): directed vectors, stall, reset and random traffic.
module tb_fp_unpack_stream;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] sig;
        logic        nan;
        logic        inf;
        logic        zero;
        logic        subn;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_sig;
    logic        out_nan, out_inf, out_zero, out_subn;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fp_unpack_stream #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .out_nan   (out_nan),
        .out_inf   (out_inf),
        .out_zero  (out_zero),
        .out_subn  (out_subn)
    );

    // Reference: value-level view of the binary32 word, sig scaled into [2^23, 2^24).
    function automatic rec_t model(input logic [31:0] w);
        rec_t r;
        int   e;
        int   m;
        int   s;
        r      = '0;
        r.sign = w[31];
        e      = int'(w[30:23]);
        m      = int'(w[22:0]);
        if (e == 255) begin
            r.exp = 10'(128);
            r.sig = 24'(m);
            if (m != 0) r.nan = 1'b1;
            else        r.inf = 1'b1;
        end else if (e == 0 && m == 0) begin
            r.zero = 1'b1;
        end else if (e == 0) begin
            r.subn = 1'b1;
`ifdef FP_UNPACK_NORM_EN
            s = 0;
            while (m < (1 << 23)) begin
                m = m * 2;
                s++;
            end
            r.sig = 24'(m);
            r.exp = 10'(-126 - s);
`else
            s     = 0;
            r.sig = 24'(m);
            r.exp = 10'(-126 + s);
`endif
        end else begin
            r.exp = 10'(e - 127);
            r.sig = 24'(m + (1 << 23));
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[30:23] = '0;
            1: w[30:23] = '1;
            2: begin
                w[30:23] = '0;
                w[22:0]  = 23'($urandom_range(1, 32'h7fffff) >> $urandom_range(0, 22));
            end
            3: w[22:0] = '0;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] d, input logic ordy,
                         output logic acc);
        in_valid  = vld;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        acc = vld && in_ready;
        if (acc) exp_q.push_back(model(d));
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t dut_rec();
        return {out_sign, out_exp, out_sig, out_nan, out_inf, out_zero, out_subn};
    endfunction

    // Monitor: pops on every output transfer and checks words held across stalls.
    initial begin
        rec_t act, req, held;
        logic held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            act = dut_rec();
            if (out_valid && held_v) begin
                tests++;
                if (act !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got %0h, required %0h", act, held);
                end
            end else if (!out_valid && held_v && rst_n) begin
                tests++;
                fails++;
                $display("FAIL stall_valid_drop: got out_valid=0, required 1");
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got word %0h, required none", act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        fails++;
                        $display("FAIL out_word: got s=%b e=%0d sig=%h f=%b%b%b%b, required s=%b e=%0d sig=%h f=%b%b%b%b",
                                 act.sign, $signed(act.exp), act.sig, act.nan, act.inf, act.zero,
                                 act.subn, req.sign, $signed(req.exp), req.sig, req.nan, req.inf,
                                 req.zero, req.subn);
                    end
                end
            end
            held_v = out_valid && !out_ready && rst_n;
            held   = act;
        end
    end

    initial begin
        logic        acc;
        logic [31:0] dir [6];
        logic [31:0] w;
        dir[0] = 32'h7f800000;
        dir[1] = 32'h7fffffff;
        dir[2] = 32'h0020aac8;
        dir[3] = 32'h00000000;
        dir[4] = 32'h42000000;
        dir[5] = 32'he97e1c91;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_flags", 64'({out_nan, out_inf, out_zero, out_subn}), 64'd0);
        check("reset_data", 64'({out_sign, out_exp, out_sig}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed words, back to back with out_ready high; checks 2-cycle latency.
        drive(1'b1, dir[0], 1'b1, acc);
        check("dir_acc0", 64'(acc), 64'd1);
        check("latency_1", 64'(out_valid), 64'd0);
        drive(1'b1, dir[1], 1'b1, acc);
        check("dir_acc1", 64'(acc), 64'd1);
        check("latency_2", 64'(out_valid), 64'd1);
        for (int i = 2; i < 6; i++) begin
            drive(1'b1, dir[i], 1'b1, acc);
            check("dir_throughput", 64'(acc), 64'd1);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, acc);
        check("dir_drained", 64'(exp_q.size()), 64'd0);

        // Three words back to back, downstream stalled for cycles 2-3.
        drive(1'b1, rand_word(), 1'b1, acc);
        check("stall_acc_a", 64'(acc), 64'd1);
        drive(1'b1, rand_word(), 1'b0, acc);
        check("stall_acc_b", 64'(acc), 64'd1);
        w = rand_word();
        drive(1'b1, w, 1'b0, acc);
        check("stall_in_ready_low", 64'(acc), 64'd0);
        for (int i = 0; i < 5 && !acc; i++) drive(1'b1, w, 1'b1, acc);
        check("stall_acc_c", 64'(acc), 64'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, acc);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic with random backpressure.
        w = rand_word();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 7), acc);
            if (acc) w = rand_word();
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, acc);
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two words in flight: they must never appear.
        drive(1'b1, rand_word(), 1'b0, acc);
        drive(1'b1, rand_word(), 1'b0, acc);
        check("inflight_acc", 64'(acc), 64'd1);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        drive(1'b1, 32'h3f800000, 1'b1, acc);
        check("post_reset_acc", 64'(acc), 64'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, acc);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_unpack_stream.md
FP_UNPACK_STREAM -- requirements
Module: fp_unpack_stream

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; legal only when MAN_W <= 2^(EXP_W-1)-2.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have in_data  input  1+EXP_W+MAN_W  packed IEEE-754 word {sign, exp, man}.
REQ-006 SHALL have in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-007 SHALL have out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-008 SHALL have out_sign  output  1  sign bit.
REQ-009 SHALL have out_exp  output  EXP_W+2  two's-complement unbiased exponent.
REQ-010 SHALL have out_sig  output  MAN_W+1  significand {hidden bit, mantissa}.
REQ-011 SHALL have out_nan, out_inf, out_zero, out_subn  output  1 each  class flags, one-hot or all zero.

Function
REQ-012 SHALL be a two-stage pipeline: S1 decodes and classifies, S2 normalises; each stage holds a valid bit.
REQ-013 SHALL transfer on in_valid && in_ready and on out_valid && out_ready only.
REQ-014 SHALL load S2 when !v2 || out_ready; S1 advances into S2 on the same edge.
REQ-015 SHALL drive in_ready = !v1 || S2-load, combinationally, and SHALL drive in_ready low while rst_n is low.
REQ-016 SHALL give 2-cycle latency and 1 word/cycle throughput with out_ready held high.
REQ-017 SHALL hold all out_* stable while out_valid && !out_ready, with no loss or duplication.
REQ-018 SHALL use bias = 2^(EXP_W-1)-1.
REQ-019 SHALL classify as follows:
- exp all-ones, man != 0: NaN.
- exp all-ones, man == 0: Inf.
- exp 0, man 0: zero.
- exp 0, man != 0: subnormal.
- otherwise: normal.
REQ-020 SHALL output, for normal: out_exp = exp-bias, out_sig = {1, man}.
REQ-021 SHALL output, for zero: out_exp = 0, out_sig = 0.
REQ-022 SHALL output, for Inf/NaN: out_exp = bias+1, out_sig = {0, man}.
REQ-023 SHALL output, for subnormal with normalisation: z = leading-zero count of man (MAN_W bits); out_sig = {0, man} << (z+1), MSB set; out_exp = 1-bias-(z+1).
REQ-024 SHALL pass out_sign through unchanged for every class, including NaN and zero.

Reset
REQ-025 SHALL clear v1, v2 and all data registers to 0 on any clk edge with rst_n low; out_valid = 0 and all flags = 0.
REQ-026 SHALL discard in-flight words when reset is asserted mid-stream; the first output after release is the first word accepted after release.

Configuration
REQ-027 SHALL compile subnormal normalisation in only when FP_UNPACK_NORM_EN is defined.
REQ-028 SHALL, without FP_UNPACK_NORM_EN, output subnormals as out_exp = 1-bias, out_sig = {0, man}, with no leading-zero logic and unchanged 2-cycle latency and handshake.

Structure
REQ-029 SHALL place the bias function, the class-flag struct/typedef and the out_exp width helper in shared package fp_pkg.
REQ-030 SHALL implement the leading-zero counter as sub-module fp_lzc, parametrised by width.

Verification (EXP_W=8, MAN_W=23, FP_UNPACK_NORM_EN defined)
REQ-031 SHALL cover 0x7f800000 -> out_inf=1, out_exp=128, out_sig=0; then 0x7fffffff -> out_nan=1, out_sig=0x7fffff.
REQ-032 SHALL cover 0x0020aac8 -> out_subn=1, out_sig=0x82ab20, out_exp=-128; and without the macro -> out_sig=0x20aac8, out_exp=-126.
REQ-033 SHALL cover 0x00000000 -> out_zero=1; 0x42000000 -> no flags, out_exp=5, out_sig=0x800000; 0xe97e1c91 -> out_sign=1, out_exp=83, out_sig=0xfe1c91.
REQ-034 SHALL cover back-to-back input of 3 words with out_ready low for cycles 2-3 -> in_ready low once both stages are full; outputs emerge in order with no loss or duplicate; outputs stay stable while stalled.
REQ-035 SHALL cover rst_n low for 1 cycle with 2 words in flight -> out_valid=0 next cycle; those words never appear at the output.
